// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: recovers b = sum - a, LSB first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH:0]   sum,
  input  logic [WIDTH-1:0] a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] b,
  output logic             borrow,
  output logic             range_err,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

  state_t         state, state_nxt;
  logic [WIDTH:0] sreg, areg, res;
  logic           bw;
  logic [CW-1:0]  cnt;
  logic           accept, consume, last;
  logic           s_bit, a_bit, d, bw_nxt;

  // in_ready is a flop that tracks IDLE, so it only ever rises in IDLE
  assign accept  = in_valid && in_ready;
  assign consume = (state == HOLD) && out_ready;
  assign last    = (cnt == CW'(WIDTH));

  assign s_bit  = sreg[0];
  assign a_bit  = areg[0];
  assign d      = s_bit ^ a_bit ^ bw;
  assign bw_nxt = (~s_bit & a_bit) | (~(s_bit ^ a_bit) & bw);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      in_ready <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = CALC;
      CALC:    if (last)    state_nxt = HOLD;
      HOLD:    if (consume) state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Result fills from the MSB side so bit 0 lands in res[0] after WIDTH+1 shifts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg <= '0;
      areg <= '0;
      res  <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
    end else if (accept) begin
      sreg <= sum;
      areg <= {1'b0, a};
      res  <= '0;
      bw   <= 1'b0;
      cnt  <= '0;
    end else if (state == CALC) begin
      sreg <= sreg >> 1;
      areg <= areg >> 1;
      res  <= {d, res[WIDTH:1]};
      bw   <= bw_nxt;
      cnt  <= cnt + 1'b1;
    end
  end

  always_comb begin
    busy      = (state != IDLE);
    out_valid = (state == HOLD);
    b         = '0;
    borrow    = 1'b0;
    range_err = 1'b0;
    if (state == HOLD) begin
      b         = res[WIDTH-1:0];
      borrow    = bw;
      range_err = res[WIDTH] & ~bw;
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor: latency, boundaries, backpressure,
// async reset abort and an exhaustive adder round trip.
module tb_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W:0]   sum = '0;
  logic [W-1:0] a = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] b;
  logic         borrow, range_err, busy;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sum(sum), .a(a), .out_valid(out_valid), .out_ready(out_ready),
    .b(b), .borrow(borrow), .range_err(range_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair, wait for in_ready, and return after the accept edge
  task automatic send(input logic [W:0] s, input logic [W-1:0] x);
    int n = 0;
    sum = s; a = x; in_valid = 1'b1;
    while (!in_ready && n < 50) begin tick(); n++; end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_ready: in_ready=%0b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    sum = W'($urandom) + 5'd0;
    a = W'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 50) begin tick(); n++; end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if ({in_ready, out_valid, b, borrow, range_err, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%0b vld=%0b b=%0d bw=%0b re=%0b busy=%0b required all 0",
               in_ready, out_valid, b, borrow, range_err, busy);
    end
    tick();
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_rdy: in_ready=%0b required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL first_edge_rdy: in_ready=%0b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n;
    send(5'd8, 4'd5);
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_busy: in_ready=%0b busy=%0b required 0 1", in_ready, busy);
    end
    wait_valid(n);
    checks++;
    if (n != 5) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d required 5", n);
    end
    checks++;
    if ({b, borrow, range_err} !== {4'd3, 2'b00}) begin
      errors++;
      $display("FAIL basic_result: b=%0d bw=%0b re=%0b required 3 0 0", b, borrow, range_err);
    end
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_after_consume: rdy=%0b vld=%0b busy=%0b required 1 0 0",
               in_ready, out_valid, busy);
    end
  endtask

  task automatic test_boundaries();
    logic [W:0]   s_t  [4] = '{5'd16, 5'd16, 5'd0, 5'd3};
    logic [W-1:0] a_t  [4] = '{4'd15, 4'd0, 4'd0, 4'd5};
    logic [W-1:0] b_t  [4] = '{4'd1, 4'd0, 4'd0, 4'd14};
    logic         bw_t [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic         re_t [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 4; i++) begin
      send(s_t[i], a_t[i]);
      wait_valid(n);
      checks++;
      if (!out_valid || {b, borrow, range_err} !== {b_t[i], bw_t[i], re_t[i]}) begin
        errors++;
        $display("FAIL boundary_%0d: vld=%0b b=%0d bw=%0b re=%0b required 1 %0d %0b %0b",
                 i, out_valid, b, borrow, range_err, b_t[i], bw_t[i], re_t[i]);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    send(5'd12, 4'd4);
    wait_valid(n);
    sum = 5'd9; a = 4'd2; in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      checks++;
      if (!out_valid || in_ready !== 1'b0 || {b, borrow, range_err} !== {4'd8, 2'b00}) begin
        errors++;
        $display("FAIL stall_hold_%0d: vld=%0b rdy=%0b b=%0d bw=%0b re=%0b required 1 0 8 0 0",
                 i, out_valid, in_ready, b, borrow, range_err);
      end
    end
    consume();
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_no_queue: busy=%0b rdy=%0b required 0 1", busy, in_ready);
    end
    send(5'd9, 4'd2);
    wait_valid(n);
    checks++;
    if (n != 5 || {b, borrow, range_err} !== {4'd7, 2'b00}) begin
      errors++;
      $display("FAIL stall_second: lat=%0d b=%0d bw=%0b re=%0b required 5 7 0 0",
               n, b, borrow, range_err);
    end
    consume();
  endtask

  task automatic test_reset_abort();
    int n;
    send(5'd8, 4'd5);
    tick(); tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, b, borrow, range_err, busy} !== '0) begin
      errors++;
      $display("FAIL abort_calc: rdy=%0b vld=%0b busy=%0b required all 0", in_ready, out_valid, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send(5'd20, 4'd3);
    wait_valid(n);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, b, borrow, range_err, busy} !== '0) begin
      errors++;
      $display("FAIL abort_hold: vld=%0b b=%0d bw=%0b re=%0b busy=%0b required all 0",
               out_valid, b, borrow, range_err, busy);
    end
    tick();
    rst_n = 1'b1;
    tick();
    send(5'd15, 4'd7);
    wait_valid(n);
    checks++;
    if (n != 5 || {b, borrow, range_err} !== {4'd8, 2'b00}) begin
      errors++;
      $display("FAIL abort_recover: lat=%0d b=%0d bw=%0b re=%0b required 5 8 0 0",
               n, b, borrow, range_err);
    end
    consume();
  endtask

  task automatic test_round_trip();
    int n;
    int bad = 0;
    logic [W:0] s;
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        s = 5'(x) + 5'(y);
        send(s, 4'(x));
        wait_valid(n);
        repeat ($urandom_range(0, 2)) tick();
        checks++;
        if (n != 5 || !out_valid || {b, borrow, range_err} !== {4'(y), 2'b00}) begin
          errors++;
          bad++;
          if (bad <= 5)
            $display("FAIL round_trip a=%0d b=%0d: lat=%0d got b=%0d bw=%0b re=%0b required 5 %0d 0 0",
                     x, y, n, b, borrow, range_err, y);
        end
        consume();
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_reset_abort();
    test_round_trip();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
